// File: rtl/frame_capture_monitor_if.sv
// Camera strobe inputs and frame statistics outputs of frame_capture_monitor.
// master drives the camera side, slave is the monitor.
interface frame_capture_monitor_if #(
   parameter int LINE_CNT_W = 12
);
   logic                  enable;
   logic                  fval;
   logic                  lval;
   logic                  image_captured;
   logic                  frame_ok;
   logic [LINE_CNT_W-1:0] last_line_count;
   logic [7:0]            error_count;
   logic                  busy;

   modport master (
      output enable, fval, lval,
      input  image_captured, frame_ok, last_line_count, error_count, busy
   );

   modport slave (
      input  enable, fval, lval,
      output image_captured, frame_ok, last_line_count, error_count, busy
   );
endinterface

// File: rtl/frame_capture_monitor.sv
// Synchronises camera FVAL/LVAL, counts lines per frame and reports frame completion
// as a stretched pulse with line-count check and saturating error counter.
module frame_capture_monitor #(
   parameter int EXPECTED_LINES = 480,
   parameter int LINE_CNT_W     = 12,
   parameter int PULSE_CYCLES   = 4
) (
   input logic                    clock_50,
   input logic                    reset_n,
   frame_capture_monitor_if.slave bus
);
   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_FRAME} state_t;

   state_t                r_state;
   logic                  r_fval_m, r_fval_s, r_fval_d;
   logic                  r_lval_m, r_lval_s, r_lval_d;
   logic [1:0]            r_settle;
   logic [LINE_CNT_W-1:0] r_line_cnt;
   logic [LINE_CNT_W-1:0] r_last_line_count;
   logic [3:0]            r_pulse_cnt;
   logic                  r_image_captured;
   logic                  r_frame_ok;
   logic                  r_busy;
   logic [7:0]            r_error_count;

   logic                  w_fval_rise, w_fval_fall, w_lval_rise;
   logic                  w_settled, w_line_sat, w_count_ok, w_complete;
   logic [3:0]            w_pulse_next;

   assign w_fval_rise = r_fval_s & ~r_fval_d;
   assign w_fval_fall = ~r_fval_s & r_fval_d;
   assign w_lval_rise = r_lval_s & ~r_lval_d;
   // Sync flops reset to 0, so their low value means nothing until the pin has propagated through all three.
   assign w_settled   = (r_settle == 2'd3);
   assign w_line_sat  = &r_line_cnt;
   assign w_count_ok  = (r_line_cnt == LINE_CNT_W'(EXPECTED_LINES));
   assign w_complete  = (r_state == S_FRAME) && w_fval_fall;

   // image_captured is registered from the next counter value so it rises on the completion edge.
   always_comb begin
      w_pulse_next = '0;
      if (w_complete)
         w_pulse_next = 4'(PULSE_CYCLES);
      else if (r_pulse_cnt != '0)
         w_pulse_next = r_pulse_cnt - 4'd1;
   end

   always_ff @(posedge clock_50) begin
      if (!reset_n) begin
         r_state           <= S_SYNC;
         r_fval_m          <= 1'b0;
         r_fval_s          <= 1'b0;
         r_fval_d          <= 1'b0;
         r_lval_m          <= 1'b0;
         r_lval_s          <= 1'b0;
         r_lval_d          <= 1'b0;
         r_settle          <= '0;
         r_line_cnt        <= '0;
         r_last_line_count <= '0;
         r_pulse_cnt       <= '0;
         r_image_captured  <= 1'b0;
         r_frame_ok        <= 1'b0;
         r_busy            <= 1'b0;
         r_error_count     <= '0;
      end else begin
         r_fval_m <= bus.fval;
         r_fval_s <= r_fval_m;
         r_fval_d <= r_fval_s;
         r_lval_m <= bus.lval;
         r_lval_s <= r_lval_m;
         r_lval_d <= r_lval_s;
         if (!w_settled)
            r_settle <= r_settle + 2'd1;

         if (!bus.enable) begin
            r_state          <= S_SYNC;
            r_busy           <= 1'b0;
            r_pulse_cnt      <= '0;
            r_image_captured <= 1'b0;
         end else begin
            r_pulse_cnt      <= w_pulse_next;
            r_image_captured <= (w_pulse_next != '0);
            case (r_state)
               S_SYNC: begin
                  r_busy <= 1'b0;
                  if (w_settled && !r_fval_s && !r_fval_d)
                     r_state <= S_IDLE;
               end
               S_IDLE: begin
                  if (w_fval_rise) begin
                     r_state    <= S_FRAME;
                     r_busy     <= 1'b1;
                     r_line_cnt <= LINE_CNT_W'(w_lval_rise);
                  end
               end
               S_FRAME: begin
                  if (w_fval_fall) begin
                     r_state           <= S_IDLE;
                     r_busy            <= 1'b0;
                     r_last_line_count <= r_line_cnt;
                     r_frame_ok        <= w_count_ok;
                     if (!w_count_ok && (r_error_count != '1))
                        r_error_count <= r_error_count + 8'd1;
                  end else if (w_lval_rise && !w_line_sat) begin
                     r_line_cnt <= r_line_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= S_SYNC;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.image_captured  = r_image_captured;
   assign bus.frame_ok        = r_frame_ok;
   assign bus.last_line_count = r_last_line_count;
   assign bus.error_count     = r_error_count;
   assign bus.busy            = r_busy;
endmodule

// File: tb/tb_frame_capture_monitor.sv
// Randomised pin-level stimulus for frame_capture_monitor, checked against a
// frame-level model of line counts, frame_ok and the saturating error count.
module tb_frame_capture_monitor;
   localparam int EXP = 480;
   localparam int W   = 12;
   localparam int PC  = 4;
   localparam logic [7:0] P_ON  = 8'b0011_1100;
   localparam logic [7:0] P_OFF = 8'b0000_0000;

   logic clock_50 = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   int   m_last = 0;
   logic m_ok   = 1'b0;
   int   m_err  = 0;

   frame_capture_monitor_if #(.LINE_CNT_W(W)) bus ();

   frame_capture_monitor #(
      .EXPECTED_LINES(EXP),
      .LINE_CNT_W    (W),
      .PULSE_CYCLES  (PC)
   ) dut (
      .clock_50(clock_50),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #10 clock_50 = ~clock_50;

   function automatic void model_complete(input int n);
      m_last = (n > 4095) ? 4095 : n;
      m_ok   = (n == EXP);
      if (!m_ok && m_err < 255)
         m_err++;
   endfunction

   task automatic send_lines(input int n);
      for (int i = 0; i < n; i++) begin
         bus.lval = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clock_50);
         bus.lval = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clock_50);
      end
   endtask

   task automatic start_frame();
      bus.fval = 1'b1;
      repeat (2) @(negedge clock_50);
   endtask

   // Drops fval and records image_captured for the following 8 cycles.
   task automatic finish_frame(output logic [7:0] tr);
      bus.fval = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock_50);
         bus.lval = 1'b0;
         tr[k] = bus.image_captured;
      end
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      bus.enable = 1'b1;
      bus.fval   = 1'b0;
      bus.lval   = 1'b0;
      repeat (3) @(negedge clock_50);
      checks++;
      if ({bus.image_captured, bus.frame_ok, bus.busy} !== 3'b000 ||
          bus.last_line_count !== '0 || bus.error_count !== 8'd0) begin
         errors++;
         $display("FAIL reset: ic=%b ok=%b busy=%b last=%0d err=%0d, expected all zero",
                  bus.image_captured, bus.frame_ok, bus.busy, bus.last_line_count, bus.error_count);
      end
      reset_n = 1'b1;
      repeat (6) @(negedge clock_50);
   endtask

   task automatic test_basic_frame();
      logic [7:0] tr;
      start_frame();
      send_lines(240);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_in_frame: got %b expected 1", bus.busy);
      end
      send_lines(240);
      finish_frame(tr);
      model_complete(480);
      checks++;
      if (tr !== P_ON || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok ||
          bus.error_count !== 8'(m_err) || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_frame: pulse=%b last=%0d ok=%b err=%0d busy=%b, expected pulse=%b last=%0d ok=%b err=%0d busy=0",
                  tr, bus.last_line_count, bus.frame_ok, bus.error_count, bus.busy, P_ON, m_last, m_ok, m_err);
      end
   endtask

   task automatic test_bad_sizes();
      logic [7:0] tr;
      int sizes[2] = '{479, 481};
      foreach (sizes[i]) begin
         start_frame();
         send_lines(sizes[i]);
         finish_frame(tr);
         model_complete(sizes[i]);
         checks++;
         if (tr !== P_ON || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok ||
             bus.error_count !== 8'(m_err)) begin
            errors++;
            $display("FAIL bad_size_%0d: pulse=%b last=%0d ok=%b err=%0d, expected pulse=%b last=%0d ok=%b err=%0d",
                     sizes[i], tr, bus.last_line_count, bus.frame_ok, bus.error_count, P_ON, m_last, m_ok, m_err);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] tr;
      start_frame();
      send_lines(100);
      reset_n = 1'b0;
      send_lines(5);
      reset_n = 1'b1;
      m_last = 0;
      m_ok   = 1'b0;
      m_err  = 0;
      send_lines(100);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_busy: got %b expected 0", bus.busy);
      end
      finish_frame(tr);
      checks++;
      if (tr !== P_OFF || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok ||
          bus.error_count !== 8'(m_err)) begin
         errors++;
         $display("FAIL rst_mid_partial: pulse=%b last=%0d ok=%b err=%0d, expected pulse=%b last=%0d ok=%b err=%0d",
                  tr, bus.last_line_count, bus.frame_ok, bus.error_count, P_OFF, m_last, m_ok, m_err);
      end
      start_frame();
      send_lines(480);
      finish_frame(tr);
      model_complete(480);
      checks++;
      if (tr !== P_ON || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok ||
          bus.error_count !== 8'(m_err)) begin
         errors++;
         $display("FAIL rst_mid_next: pulse=%b last=%0d ok=%b err=%0d, expected pulse=%b last=%0d ok=%b err=%0d",
                  tr, bus.last_line_count, bus.frame_ok, bus.error_count, P_ON, m_last, m_ok, m_err);
      end
   endtask

   task automatic test_enable_mid_frame();
      logic [7:0] tr;
      start_frame();
      send_lines(200);
      bus.enable = 1'b0;
      send_lines(3);
      bus.enable = 1'b1;
      send_lines(100);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL en_mid_busy: got %b expected 0", bus.busy);
      end
      finish_frame(tr);
      checks++;
      if (tr !== P_OFF || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok ||
          bus.error_count !== 8'(m_err)) begin
         errors++;
         $display("FAIL en_mid_held: pulse=%b last=%0d ok=%b err=%0d, expected pulse=%b last=%0d ok=%b err=%0d",
                  tr, bus.last_line_count, bus.frame_ok, bus.error_count, P_OFF, m_last, m_ok, m_err);
      end
      start_frame();
      send_lines(481);
      finish_frame(tr);
      model_complete(481);
      checks++;
      if (tr !== P_ON || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok ||
          bus.error_count !== 8'(m_err)) begin
         errors++;
         $display("FAIL en_mid_next: pulse=%b last=%0d ok=%b err=%0d, expected pulse=%b last=%0d ok=%b err=%0d",
                  tr, bus.last_line_count, bus.frame_ok, bus.error_count, P_ON, m_last, m_ok, m_err);
      end
   endtask

   task automatic test_edge_coincidence();
      logic [7:0] tr;
      start_frame();
      send_lines(480);
      bus.lval = 1'b1;
      finish_frame(tr);
      model_complete(480);
      checks++;
      if (tr !== P_ON || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok) begin
         errors++;
         $display("FAIL lval_at_fall: pulse=%b last=%0d ok=%b, expected pulse=%b last=%0d ok=%b",
                  tr, bus.last_line_count, bus.frame_ok, P_ON, m_last, m_ok);
      end
      bus.fval = 1'b1;
      bus.lval = 1'b1;
      repeat (2) @(negedge clock_50);
      bus.lval = 1'b0;
      repeat (2) @(negedge clock_50);
      send_lines(479);
      finish_frame(tr);
      model_complete(480);
      checks++;
      if (tr !== P_ON || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok) begin
         errors++;
         $display("FAIL lval_at_rise: pulse=%b last=%0d ok=%b, expected pulse=%b last=%0d ok=%b",
                  tr, bus.last_line_count, bus.frame_ok, P_ON, m_last, m_ok);
      end
   endtask

   task automatic test_random_frames();
      logic [7:0] tr;
      int n;
      for (int f = 0; f < 4; f++) begin
         n = ($urandom_range(0, 1) == 0) ? EXP : int'($urandom_range(476, 484));
         repeat ($urandom_range(0, 5)) @(negedge clock_50);
         start_frame();
         send_lines(n);
         finish_frame(tr);
         model_complete(n);
         checks++;
         if (tr !== P_ON || bus.last_line_count !== W'(m_last) || bus.frame_ok !== m_ok ||
             bus.error_count !== 8'(m_err)) begin
            errors++;
            $display("FAIL random_frame_%0d(n=%0d): pulse=%b last=%0d ok=%b err=%0d, expected pulse=%b last=%0d ok=%b err=%0d",
                     f, n, tr, bus.last_line_count, bus.frame_ok, bus.error_count, P_ON, m_last, m_ok, m_err);
         end
      end
   endtask

   task automatic test_error_saturation();
      int n;
      for (int f = 0; f < 305; f++) begin
         n = $urandom_range(0, 3);
         start_frame();
         send_lines(n);
         bus.fval = 1'b0;
         repeat (3) @(negedge clock_50);
         model_complete(n);
         if (f == 299) begin
            repeat (10) @(negedge clock_50);
            checks++;
            if (bus.error_count !== 8'd255 || bus.last_line_count !== W'(m_last) || bus.frame_ok !== 1'b0) begin
               errors++;
               $display("FAIL err_saturate: err=%0d last=%0d ok=%b, expected err=255 last=%0d ok=0",
                        bus.error_count, bus.last_line_count, bus.frame_ok, m_last);
            end
         end
      end
      repeat (10) @(negedge clock_50);
      checks++;
      if (bus.error_count !== 8'd255 || bus.last_line_count !== W'(m_last)) begin
         errors++;
         $display("FAIL err_hold: err=%0d last=%0d, expected err=255 last=%0d",
                  bus.error_count, bus.last_line_count, m_last);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_bad_sizes();
      test_reset_mid_frame();
      test_enable_mid_frame();
      test_edge_coincidence();
      test_random_frames();
      test_error_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_capture_monitor.md
Name: frame_capture_monitor

Overview:
- Upstream stage of the frame-rate display controller; produces its image_captured input from the raw camera frame/line valid strobes.
- Synchronises asynchronous FVAL/LVAL into the clock_50 domain, tracks frame boundaries with an FSM and counts lines per frame.
- Emits a stretched end-of-frame pulse, the last frame's line count, a frame-size check flag and a saturating error counter.

Parameters:
- EXPECTED_LINES, 480, line count a correct frame must contain.
- LINE_CNT_W, 12, width of line counters.
- PULSE_CYCLES, 4, clock_50 cycles image_captured stays high per completed frame (1..15).

Ports:
- clock_50  in  1  system clock, 50 MHz.
- reset_n  in  1  reset; synchronous, active-low.
- enable  in  1  monitoring enable, synchronous.
- fval  in  1  camera frame valid, asynchronous.
- lval  in  1  camera line valid, asynchronous.
- image_captured  out  1  end-of-frame pulse, PULSE_CYCLES wide.
- frame_ok  out  1  last completed frame had exactly EXPECTED_LINES lines.
- last_line_count  out  LINE_CNT_W  line count of last completed frame.
- error_count  out  8  completed frames with wrong line count, saturating.
- busy  out  1  high while in S_FRAME.

Behaviour:
- Clock is clock_50. Reset is reset_n, synchronous, active-low.
- Reset values: image_captured 0, frame_ok 0, last_line_count 0, error_count 0, busy 0. Sync flops 0, line counter 0, pulse counter 0, state S_SYNC.
- Synchronisers: fval and lval each pass through 2 flops (fval_s, lval_s), then 1 delay flop (fval_d, lval_d).
  - fval_rise = fval_s & ~fval_d; fval_fall = ~fval_s & fval_d; lval_rise = lval_s & ~lval_d.
  - Edges are decoded from registered values only.
- FSM states:
  - S_SYNC: wait for fval_s == 0, then S_IDLE. Prevents counting a partial frame after reset or enable.
  - S_IDLE: on fval_rise, clear line counter, go to S_FRAME. If lval_rise occurs in the same cycle, line counter loads 1.
  - S_FRAME: busy = 1. Each lval_rise increments the line counter, saturating at all-ones. On fval_fall, go to S_IDLE and complete the frame. An lval_rise in the same cycle as fval_fall is not counted.
- Frame completion, registered in the fval_fall cycle and visible after the next edge:
  - last_line_count <= line counter.
  - frame_ok <= (line counter == EXPECTED_LINES).
  - If the count mismatches, error_count increments, saturating at 255.
  - The pulse counter loads PULSE_CYCLES.
- image_captured is registered as (pulse counter != 0); the counter decrements each cycle while nonzero.
  - A new completion while the counter is nonzero reloads it, giving one merged pulse. Frames shorter than PULSE_CYCLES+1 cycles are not separately visible downstream.
- Latency: first clock edge sampling fval low at the pin is edge 1; fval_fall is true after edge 2; image_captured is high after edge 3 and stays high for exactly PULSE_CYCLES cycles.
- enable low, checked with priority below reset:
  - Go to S_SYNC and discard the frame in progress (no completion, no pulse).
  - Clear the pulse counter.
  - Hold last_line_count, frame_ok and error_count.
  - Sync flops keep sampling.
- enable re-asserted mid-frame: S_SYNC waits for fval low, so the partial frame is never reported.
- Reset mid-frame: all state returns to reset values on the next edge; a running pulse is cut.
- lval activity while in S_IDLE or S_SYNC is ignored.
- Width rule: line counter is LINE_CNT_W bits. The EXPECTED_LINES comparison uses the full width, so saturation at all-ones is always a mismatch when EXPECTED_LINES is below all-ones.

Test Plan:
- Reset, then a frame of fval high with 480 lval pulses, then fval low -> image_captured high 4 cycles, starting 3 edges after fval falls; last_line_count = 480; frame_ok = 1; error_count = 0.
- Frame with 479 lines, then one with 481 -> frame_ok = 0 after each; last_line_count 479 then 481; error_count = 2; two separate 4-cycle pulses.
- Release reset while fval is high mid-frame -> no pulse for that frame; next full 480-line frame reports normally with frame_ok = 1.
- Deassert enable halfway through a frame, re-assert before fval falls -> no pulse, outputs held; next frame counted from its start.
- Drive lval rising in the same synchronised cycle as fval falling, with 480 lines before it -> count stays 480. Drive lval rising with fval rising on a 480-line frame -> first line counted, count 480.
- Force 300 bad frames -> error_count saturates at 255 and holds.
